// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: widths, opcodes, FSM states
// and the accumulator ALU.
package cpu_pkg;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FETCH = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } state_e;

    // New accumulator value; opcodes that do not touch Acc return it unchanged.
    function automatic logic [DW-1:0] alu(input opcode_e op,
                                          input logic [DW-1:0] acc,
                                          input logic [DW-1:0] operand);
        case (op)
            OP_ADD:  return acc + operand;
            OP_AND:  return acc & operand;
            OP_XOR:  return acc ^ operand;
            OP_LDA:  return operand;
            default: return acc;
        endcase
    endfunction

endpackage

// File: rtl/cpu_mem.sv
// 32x8 unified program/data memory: combinational read, synchronous write.
// Contents are deliberately not cleared by reset.
module cpu_mem
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/cpu.sv
// Accumulator CPU top: serial program loader, two-cycle FETCH/EXEC sequencer,
// ALU and architectural registers around the shared memory.
module cpu
    import cpu_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          Load,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] Instruction,
    output logic [DW-1:0] Acc,
    output logic [DW-1:0] Mem,
    output logic [AW-1:0] Program_counter
);

    state_e        state_reg;
    logic [AW-1:0] pc_reg;
    logic [AW-1:0] lp_reg;
    logic [DW-1:0] acc_reg;
    logic [DW-1:0] ir_reg;

    opcode_e       op;
    logic [AW-1:0] operand_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] load_addr;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    assign op           = opcode_e'(ir_reg[7:5]);
    assign operand_addr = ir_reg[AW-1:0];

    // A fresh load burst always restarts at address 0.
    assign load_addr = (state_reg == LOAD) ? lp_reg : '0;

    always_comb begin
        rd_addr = lp_reg;
        case (state_reg)
            FETCH:      rd_addr = pc_reg;
            EXEC, HALT: rd_addr = operand_addr;
            default:    rd_addr = lp_reg;
        endcase
    end

    // Load takes priority over a STO in flight; reset suppresses any write.
    assign we      = !reset && (Load || (state_reg == EXEC && op == OP_STO));
    assign wr_addr = Load ? load_addr : operand_addr;
    assign wr_data = Load ? data_in : acc_reg;

    cpu_mem u_mem (
        .clk     (clock),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            lp_reg    <= '0;
            acc_reg   <= '0;
            ir_reg    <= '0;
        end else if (Load) begin
            state_reg <= LOAD;
            lp_reg    <= load_addr + AW'(1);
        end else begin
            case (state_reg)
                IDLE: state_reg <= IDLE;
                LOAD: begin
                    state_reg <= FETCH;
                    pc_reg    <= '0;
                    acc_reg   <= '0;
                    ir_reg    <= '0;
                end
                FETCH: begin
                    ir_reg    <= rd_data;
                    pc_reg    <= pc_reg + AW'(1);
                    state_reg <= EXEC;
                end
                EXEC: begin
                    state_reg <= (op == OP_HLT) ? HALT : FETCH;
                    acc_reg   <= alu(op, acc_reg, rd_data);
                    if (op == OP_SKZ && acc_reg == '0) begin
                        pc_reg <= pc_reg + AW'(1);
                    end else if (op == OP_JMP) begin
                        pc_reg <= operand_addr;
                    end
                end
                HALT:    state_reg <= HALT;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign Instruction     = ir_reg;
    assign Acc             = acc_reg;
    assign Mem             = rd_data;
    assign Program_counter = pc_reg;

endmodule

// File: tb/tb_cpu.sv
// Directed-program testbench for the accumulator CPU: stimulus pushes expected
// values into a scoreboard queue, a monitor pops and compares them.
module tb_cpu;
    import cpu_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       Load;
    logic [7:0] data_in;
    logic [7:0] Instruction;
    logic [7:0] Acc;
    logic [7:0] Mem;
    logic [4:0] Program_counter;

    cpu dut (
        .clock           (clock),
        .reset           (reset),
        .Load            (Load),
        .data_in         (data_in),
        .Instruction     (Instruction),
        .Acc             (Acc),
        .Mem             (Mem),
        .Program_counter (Program_counter)
    );

    always #5 clock = ~clock;

    localparam int K_PC    = 0;
    localparam int K_ACC   = 1;
    localparam int K_IR    = 2;
    localparam int K_MEM   = 3;
    localparam int K_STATE = 4;
    localparam int K_MW    = 5;

    typedef struct {
        string      name;
        int         kind;
        int         addr;
        logic [7:0] exp;
    } exp_t;

    exp_t       sb[$];
    event       sample_ev;
    int         total  = 0;
    int         passed = 0;
    logic [7:0] prog[$];

    // Monitor: on each sample request, drain the scoreboard against the DUT.
    initial begin
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                exp_t       e;
                logic [7:0] act;
                e = sb.pop_front();
                case (e.kind)
                    K_PC:    act = {3'b000, Program_counter};
                    K_ACC:   act = Acc;
                    K_IR:    act = Instruction;
                    K_MEM:   act = Mem;
                    K_STATE: act = 8'(dut.state_reg);
                    default: act = dut.u_mem.mem_reg[e.addr];
                endcase
                total++;
                if (act === e.exp) begin
                    passed++;
                    $display("check %s: got %02h ok", e.name, act);
                end else begin
                    $display("FAIL %s: got %02h expected %02h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic chk(input string name, input int kind, input int addr, input logic [7:0] exp);
        exp_t e;
        e.name = name; e.kind = kind; e.addr = addr; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic sample();
        -> sample_ev;
        #0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Loads prog[] from address 0, then spends the LOAD->FETCH cycle.
    task automatic load_prog();
        foreach (prog[i]) begin
            Load = 1'b1; data_in = prog[i];
            step(1);
        end
        Load = 1'b0; data_in = 8'h00;
        step(1);
    endtask

    task automatic wait_halt(input string name);
        int i;
        for (i = 0; i < 200 && dut.state_reg != HALT; i++) step(1);
        if (dut.state_reg != HALT) begin
            total++;
            $display("FAIL %s: no halt within 200 cycles, state %0d expected %0d",
                     name, dut.state_reg, HALT);
        end
    endtask

    initial begin
        reset = 1'b1; Load = 1'b0; data_in = 8'h00;
        step(2);
        reset = 1'b0;
        chk("rst_pc", K_PC, 0, 8'h00);
        chk("rst_acc", K_ACC, 0, 8'h00);
        chk("rst_ir", K_IR, 0, 8'h00);
        chk("rst_state", K_STATE, 0, 8'(IDLE));
        sample();
        step(3);
        chk("idle_stays", K_STATE, 0, 8'(IDLE));
        sample();

        // LDA 3 / ADD 4 / HLT
        prog = '{8'hA3, 8'h44, 8'h00, 8'h05, 8'h07};
        load_prog();
        chk("first_fetch_state", K_STATE, 0, 8'(FETCH));
        chk("first_fetch_pc", K_PC, 0, 8'h00);
        sample();
        step(6);
        chk("p1_state", K_STATE, 0, 8'(HALT));
        chk("p1_acc", K_ACC, 0, 8'h0C);
        chk("p1_pc", K_PC, 0, 8'h03);
        chk("p1_ir", K_IR, 0, 8'h00);
        chk("p1_mem_halt", K_MEM, 0, 8'hA3);
        sample();
        step(20);
        chk("p1_acc_hold", K_ACC, 0, 8'h0C);
        chk("p1_pc_hold", K_PC, 0, 8'h03);
        sample();

        prog = '{8'hA3, 8'h44, 8'h00, 8'hFF, 8'h01};
        load_prog();
        wait_halt("add_wrap");
        chk("add_wrap_acc", K_ACC, 0, 8'h00);
        chk("add_wrap_pc", K_PC, 0, 8'h03);
        sample();

        prog = '{8'hA5, 8'h20, 8'h00, 8'h00, 8'hE0, 8'h00};
        load_prog();
        wait_halt("skz0");
        chk("skz0_pc", K_PC, 0, 8'h04);
        chk("skz0_acc", K_ACC, 0, 8'h00);
        sample();

        prog = '{8'hA5, 8'h20, 8'h00, 8'h00, 8'hE0, 8'h01};
        load_prog();
        wait_halt("skz1");
        chk("skz1_pc", K_PC, 0, 8'h03);
        chk("skz1_acc", K_ACC, 0, 8'h01);
        sample();

        // LDA 6 / XOR 7 / STO 8 / LDA 8 / HLT
        prog = '{8'hA6, 8'h87, 8'hC8, 8'hA8, 8'h00, 8'h00, 8'hAA, 8'hFF};
        load_prog();
        wait_halt("sto");
        chk("sto_acc", K_ACC, 0, 8'h55);
        chk("sto_m8", K_MW, 8, 8'h55);
        sample();

        prog = '{8'hA6, 8'h67, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h0F};
        load_prog();
        wait_halt("and");
        chk("and_acc", K_ACC, 0, 8'h05);
        sample();

        prog = '{8'hE3, 8'h00, 8'h00, 8'h00};
        load_prog();
        step(2);
        chk("jmp_pc", K_PC, 0, 8'h03);
        chk("jmp_ir", K_IR, 0, 8'hE3);
        sample();
        wait_halt("jmp_halt");
        chk("jmp_halt_pc", K_PC, 0, 8'h04);
        sample();

        prog = '{8'hE0};
        load_prog();
        for (int i = 0; i < 5; i++) begin
            step(2);
            chk("jself_state", K_STATE, 0, 8'(FETCH));
            chk("jself_pc", K_PC, 0, 8'h00);
            sample();
        end

        // LDA 6 / ADD 7 / ADD 7 / JMP 0 loop, reset after three instructions
        prog = '{8'hA6, 8'h47, 8'h47, 8'hE0, 8'h00, 8'h00, 8'h10, 8'h03};
        load_prog();
        step(6);
        chk("pre_rst_acc", K_ACC, 0, 8'h16);
        sample();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_rst_pc", K_PC, 0, 8'h00);
        chk("mid_rst_acc", K_ACC, 0, 8'h00);
        chk("mid_rst_ir", K_IR, 0, 8'h00);
        chk("mid_rst_state", K_STATE, 0, 8'(IDLE));
        chk("mid_rst_mem", K_MEM, 0, 8'hA6);
        sample();
        reset = 1'b1; Load = 1'b1; data_in = 8'hFF;
        step(1);
        reset = 1'b0; Load = 1'b0; data_in = 8'h00;
        chk("rst_load_state", K_STATE, 0, 8'(IDLE));
        chk("rst_load_m0", K_MW, 0, 8'hA6);
        sample();

        prog = '{8'hA6, 8'h47, 8'h00};
        load_prog();
        wait_halt("reload");
        chk("reload_acc", K_ACC, 0, 8'h13);
        chk("reload_pc", K_PC, 0, 8'h03);
        chk("reload_m3", K_MW, 3, 8'hE0);
        chk("reload_m7", K_MW, 7, 8'h03);
        sample();

        step(1);
        if (sb.size() != 0) begin
            total += sb.size();
            $display("FAIL scoreboard: %0d unchecked entries, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
